// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, multi-read register file with per-entry busy scoreboard
// Reads are combinational with optional same-cycle write forwarding; busy_cnt tracks set busy bits.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  wen1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic [ADDR_W:0]       busy_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Port 1 is applied after port 0 so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (wen0 && !is_zero_reg(waddr0)) mem_d[waddr0] = wdata0;
        if (wen1 && !is_zero_reg(waddr1)) mem_d[waddr1] = wdata1;
    end

    // Clear before set so a producer issued in the same cycle as a write keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (wen0) busy_d[waddr0] = 1'b0;
        if (wen1) busy_d[waddr1] = 1'b0;
        if (sb_set) busy_d[sb_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [ADDR_W-1:0] ra;
            logic              hit0, hit1, set_hit;
            ra      = raddr[k*ADDR_W +: ADDR_W];
            hit0    = (BYPASS != 0) && wen0 && (waddr0 == ra);
            hit1    = (BYPASS != 0) && wen1 && (waddr1 == ra);
            set_hit = sb_set && (sb_addr == ra);
            if (rst || is_zero_reg(ra)) begin
                rdata[k*DATA_W +: DATA_W] = '0;
                rbusy[k]                  = 1'b0;
            end else begin
                if (hit1)      rdata[k*DATA_W +: DATA_W] = wdata1;
                else if (hit0) rdata[k*DATA_W +: DATA_W] = wdata0;
                else           rdata[k*DATA_W +: DATA_W] = mem_q[ra];
                rbusy[k] = busy_q[ra] && !((hit0 || hit1) && !set_hit);
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
